// File: rtl/rgmii_pkg.sv
// Shared types for the RGMII receive path: speed codes, in-band status fields,
// and the nibble assembly FSM state.
package rgmii_pkg;

    typedef enum logic [1:0] {
        SPD_10   = 2'b00,
        SPD_100  = 2'b01,
        SPD_1000 = 2'b10
    } speed_t;

    typedef struct packed {
        logic       link;
        logic [1:0] speed;
        logic       duplex;
    } rgmii_status_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOW  = 2'b01,
        ST_HIGH = 2'b10
    } nib_state_t;

    // In-band status occupies the rising-edge nibble during inter-frame gaps.
    function automatic rgmii_status_t decode_status(input logic [3:0] dat);
        rgmii_status_t s;
        s.link   = dat[0];
        s.speed  = dat[2:1];
        s.duplex = dat[3];
        return s;
    endfunction

endpackage

// File: rtl/rgmii_inband_status_filter.sv
// Debounces RGMII in-band link status and produces the status change pulse,
// merging in speed changes that the adapter applies later than link/duplex.
module rgmii_inband_status_filter
    import rgmii_pkg::*;
#(
    parameter logic [1:0] DEFAULT_SPEED = 2'b10,
    parameter int         STATUS_FILTER = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] ddr_dat_l,
    input  logic       ddr_ctl_l,
    input  logic       ddr_ctl_h,
    input  logic       speed_upd,
    output logic       link_up,
    output logic       full_duplex,
    output logic [1:0] filt_speed_nxt,
    output logic       status_chg
);

    localparam logic [7:0] FILT_MAX = 8'(STATUS_FILTER);

    rgmii_status_t smp;
    rgmii_status_t prev_smp;
    logic          smp_take;
    logic          smp_ok;
    logic [7:0]    cnt;
    logic [7:0]    cnt_nxt;
    logic [1:0]    filt_speed;
    logic          link_nxt;
    logic          dup_nxt;

    // Only ctl = 00 carries status; other inter-frame codes leave the run count alone.
    always_comb begin
        smp            = decode_status(ddr_dat_l);
        smp_take       = !ddr_ctl_l && !ddr_ctl_h;
        smp_ok         = (smp.speed != 2'b11);
        cnt_nxt        = cnt;
        link_nxt       = link_up;
        dup_nxt        = full_duplex;
        filt_speed_nxt = filt_speed;
        if (smp_take) begin
            if (!smp_ok) begin
                cnt_nxt = 8'd0;
            end else if (smp == prev_smp) begin
                cnt_nxt = (cnt >= FILT_MAX) ? FILT_MAX : cnt + 8'd1;
            end else begin
                cnt_nxt = 8'd1;
            end
            if (smp_ok && cnt_nxt == FILT_MAX) begin
                link_nxt = smp.link;
                dup_nxt  = smp.duplex;
                // A link-down report carries no trustworthy speed.
                if (smp.link) begin
                    filt_speed_nxt = smp.speed;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= 8'd0;
            prev_smp    <= '0;
            link_up     <= 1'b0;
            full_duplex <= 1'b0;
            filt_speed  <= DEFAULT_SPEED;
            status_chg  <= 1'b0;
        end else begin
            cnt         <= cnt_nxt;
            if (smp_take && smp_ok) begin
                prev_smp <= smp;
            end
            link_up     <= link_nxt;
            full_duplex <= dup_nxt;
            filt_speed  <= filt_speed_nxt;
            status_chg  <= (link_nxt != link_up) || (dup_nxt != full_duplex) || speed_upd;
        end
    end

endmodule

// File: rtl/rgmii_rx_mode_adapter.sv
// RGMII receive stage: rebuilds GMII bytes at 1000M or from nibble pairs at
// 10/100M, follows in-band status for the active speed, and counts anomalies.
module rgmii_rx_mode_adapter
    import rgmii_pkg::*;
#(
    parameter int         SPEED_AUTO    = 1,
    parameter logic [1:0] DEFAULT_SPEED = 2'b10,
    parameter int         STATUS_FILTER = 4,
    parameter int         CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       ddr_dat_l,
    input  logic [3:0]       ddr_dat_h,
    input  logic             ddr_ctl_l,
    input  logic             ddr_ctl_h,
    input  logic [1:0]       speed_force,
    output logic [7:0]       gmii_rx_dat,
    output logic             gmii_rx_val,
    output logic             gmii_rx_err,
    output logic             link_up,
    output logic [1:0]       speed,
    output logic             full_duplex,
    output logic             status_chg,
    output logic [CNT_W-1:0] odd_nib_cnt,
    output logic [CNT_W-1:0] rx_err_cnt
);

    nib_state_t state;
    nib_state_t state_nxt;
    logic [3:0] low_nib;
    logic [3:0] low_nxt;
    logic       pend_err;
    logic       pend_nxt;
    logic       dv;
    logic       er;
    logic [7:0] dat_nxt;
    logic       val_nxt;
    logic       err_nxt;
    logic       odd_inc;
    logic [1:0] filt_speed_nxt;
    logic [1:0] speed_target;
    logic       speed_apply;
    logic       speed_upd;

    assign dv           = ddr_ctl_l;
    assign er           = ddr_ctl_l ^ ddr_ctl_h;
    assign speed_target = (SPEED_AUTO != 0) ? filt_speed_nxt : speed_force;
    // Speed may only move between frames so a byte is never split across modes.
    assign speed_apply  = (state == ST_IDLE) && !dv;
    assign speed_upd    = speed_apply && (speed_target != speed);

    rgmii_inband_status_filter #(
        .DEFAULT_SPEED (DEFAULT_SPEED),
        .STATUS_FILTER (STATUS_FILTER)
    ) u_status_filter (
        .clk            (clk),
        .rst            (rst),
        .ddr_dat_l      (ddr_dat_l),
        .ddr_ctl_l      (ddr_ctl_l),
        .ddr_ctl_h      (ddr_ctl_h),
        .speed_upd      (speed_upd),
        .link_up        (link_up),
        .full_duplex    (full_duplex),
        .filt_speed_nxt (filt_speed_nxt),
        .status_chg     (status_chg)
    );

    always_comb begin
        state_nxt = state;
        low_nxt   = low_nib;
        pend_nxt  = pend_err;
        dat_nxt   = 8'h00;
        val_nxt   = 1'b0;
        err_nxt   = 1'b0;
        odd_inc   = 1'b0;
        if (speed == SPD_1000) begin
            dat_nxt   = {ddr_dat_h, ddr_dat_l};
            val_nxt   = dv;
            err_nxt   = er;
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE, ST_LOW: begin
                    if (dv) begin
                        low_nxt   = ddr_dat_l;
                        pend_nxt  = er;
                        state_nxt = ST_HIGH;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
                ST_HIGH: begin
                    val_nxt  = 1'b1;
                    pend_nxt = 1'b0;
                    if (dv) begin
                        dat_nxt   = {ddr_dat_l, low_nib};
                        err_nxt   = pend_err | er;
                        state_nxt = ST_LOW;
                    end else begin
                        // Frame ended on a lone nibble: flush it flagged as bad.
                        dat_nxt   = {4'h0, low_nib};
                        err_nxt   = 1'b1;
                        odd_inc   = 1'b1;
                        state_nxt = ST_IDLE;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            low_nib     <= 4'h0;
            pend_err    <= 1'b0;
            gmii_rx_dat <= 8'h00;
            gmii_rx_val <= 1'b0;
            gmii_rx_err <= 1'b0;
            speed       <= DEFAULT_SPEED;
            odd_nib_cnt <= '0;
            rx_err_cnt  <= '0;
        end else begin
            state       <= state_nxt;
            low_nib     <= low_nxt;
            pend_err    <= pend_nxt;
            gmii_rx_dat <= dat_nxt;
            gmii_rx_val <= val_nxt;
            gmii_rx_err <= err_nxt;
            if (speed_apply) begin
                speed <= speed_target;
            end
            if (odd_inc && odd_nib_cnt != '1) begin
                odd_nib_cnt <= odd_nib_cnt + CNT_W'(1);
            end
            if (val_nxt && err_nxt && rx_err_cnt != '1) begin
                rx_err_cnt <= rx_err_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_rgmii_rx_mode_adapter.sv
// Bench for rgmii_rx_mode_adapter: directed scenarios plus randomized traffic,
// all checked against a frame-level reference model.
module tb_rgmii_rx_mode_adapter;

    localparam int         FILTER   = 4;
    localparam int         CW       = 4;
    localparam logic [1:0] DEF_SPD  = 2'b10;
    localparam logic [3:0] CNT_SAT  = 4'hF;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    ddr_dat_l;
    logic [3:0]    ddr_dat_h;
    logic          ddr_ctl_l;
    logic          ddr_ctl_h;
    logic [1:0]    speed_force;
    logic [7:0]    gmii_rx_dat;
    logic          gmii_rx_val;
    logic          gmii_rx_err;
    logic          link_up;
    logic [1:0]    speed;
    logic          full_duplex;
    logic          status_chg;
    logic [CW-1:0] odd_nib_cnt;
    logic [CW-1:0] rx_err_cnt;

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model state
    logic [7:0] m_dat;
    logic       m_val, m_err, m_link, m_dup, m_chg, m_err_vis, m_rst_cyc;
    logic [1:0] m_speed, f_speed;
    logic [3:0] m_odd, m_errc, prev_smp, low;
    logic       have_low, perr, in_frame;
    int         run;

    // Scratch for the stimulus sections
    int          kind, len, pulses;
    logic        prev_val;
    logic [3:0]  s;
    logic [7:0]  b;
    logic [7:0]  got_q[$];
    logic [3:0]  nibs[$];
    logic [3:0]  stat_tab[6] = '{4'b1011, 4'b0011, 4'b1101, 4'b0000, 4'b0111, 4'b1001};

    always #5 clk = ~clk;

    rgmii_rx_mode_adapter #(
        .SPEED_AUTO    (1),
        .DEFAULT_SPEED (DEF_SPD),
        .STATUS_FILTER (FILTER),
        .CNT_W         (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ddr_dat_l   (ddr_dat_l),
        .ddr_dat_h   (ddr_dat_h),
        .ddr_ctl_l   (ddr_ctl_l),
        .ddr_ctl_h   (ddr_ctl_h),
        .speed_force (speed_force),
        .gmii_rx_dat (gmii_rx_dat),
        .gmii_rx_val (gmii_rx_val),
        .gmii_rx_err (gmii_rx_err),
        .link_up     (link_up),
        .speed       (speed),
        .full_duplex (full_duplex),
        .status_chg  (status_chg),
        .odd_nib_cnt (odd_nib_cnt),
        .rx_err_cnt  (rx_err_cnt)
    );

    task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", tag, $time, got, exp);
        end
    endtask

    // Advances the model by one clock using the inputs present at the edge.
    task automatic modelStep();
        logic       dv, er, old_link, old_dup;
        logic [1:0] old_speed;
        if (rst) begin
            m_dat = 8'h00; m_val = 1'b0; m_err = 1'b0; m_err_vis = 1'b1; m_rst_cyc = 1'b1;
            m_link = 1'b0; m_dup = 1'b0; m_chg = 1'b0; m_speed = DEF_SPD; f_speed = DEF_SPD;
            m_odd = 4'h0; m_errc = 4'h0; prev_smp = 4'h0; run = 0;
            have_low = 1'b0; perr = 1'b0; low = 4'h0; in_frame = 1'b0;
            return;
        end
        dv = ddr_ctl_l;
        er = ddr_ctl_l ^ ddr_ctl_h;
        old_link = m_link; old_dup = m_dup; old_speed = m_speed;
        m_rst_cyc = 1'b0;
        m_val = 1'b0; m_err = 1'b0; m_dat = 8'h00;
        m_err_vis = (m_speed == 2'b10);
        if (m_speed == 2'b10) begin
            m_dat = {ddr_dat_h, ddr_dat_l};
            m_val = dv;
            m_err = er;
        end else if (dv) begin
            if (!have_low) begin
                have_low = 1'b1; low = ddr_dat_l; perr = er;
            end else begin
                m_dat = {ddr_dat_l, low}; m_val = 1'b1; m_err = perr | er; have_low = 1'b0;
            end
        end else if (have_low) begin
            m_dat = {4'h0, low}; m_val = 1'b1; m_err = 1'b1; have_low = 1'b0;
            if (m_odd != CNT_SAT) m_odd++;
        end
        if (m_val && m_err && m_errc != CNT_SAT) m_errc++;
        if (!ddr_ctl_l && !ddr_ctl_h) begin
            if (ddr_dat_l[2:1] == 2'b11) begin
                run = 0;
            end else begin
                if (ddr_dat_l != prev_smp) run = 1;
                else if (run < FILTER) run++;
                prev_smp = ddr_dat_l;
                if (run == FILTER) begin
                    m_link = ddr_dat_l[0];
                    m_dup  = ddr_dat_l[3];
                    if (ddr_dat_l[0]) f_speed = ddr_dat_l[2:1];
                end
            end
        end
        if (!in_frame && !dv) m_speed = f_speed;
        in_frame = (old_speed != 2'b10) && dv;
        m_chg = (m_link != old_link) || (m_dup != old_dup) || (m_speed != old_speed);
    endtask

    task automatic compareAll();
        checkOutput("val", 16'(gmii_rx_val), 16'(m_val));
        if (m_val || m_rst_cyc) checkOutput("dat", 16'(gmii_rx_dat), 16'(m_dat));
        if (m_val || m_err_vis) checkOutput("err", 16'(gmii_rx_err), 16'(m_err));
        checkOutput("link_up", 16'(link_up), 16'(m_link));
        checkOutput("speed", 16'(speed), 16'(m_speed));
        checkOutput("full_duplex", 16'(full_duplex), 16'(m_dup));
        checkOutput("status_chg", 16'(status_chg), 16'(m_chg));
        checkOutput("odd_nib_cnt", 16'(odd_nib_cnt), 16'(m_odd));
        checkOutput("rx_err_cnt", 16'(rx_err_cnt), 16'(m_errc));
    endtask

    task automatic applyStimulus(input logic r, input logic [3:0] l, input logic [3:0] h,
                                 input logic c_l, input logic c_h);
        rst = r; ddr_dat_l = l; ddr_dat_h = h; ddr_ctl_l = c_l; ddr_ctl_h = c_h;
        @(posedge clk);
        modelStep();
        #1;
        compareAll();
    endtask

    initial begin
        speed_force = 2'b01;
        // Reset state
        applyStimulus(1'b1, 4'h0, 4'h0, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'h0, 4'h0, 1'b0, 1'b0);
        checkOutput("reset_speed", 16'(speed), 16'(DEF_SPD));
        checkOutput("reset_val", 16'(gmii_rx_val), 16'h0);

        // Gigabit 64-byte frame, RX_ER clear
        got_q.delete();
        for (int i = 0; i < 64; i++) begin
            b = 8'(i * 37 + 11);
            applyStimulus(1'b0, b[3:0], b[7:4], 1'b1, 1'b1);
            if (gmii_rx_val) got_q.push_back(gmii_rx_dat);
        end
        applyStimulus(1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
        if (gmii_rx_val) got_q.push_back(gmii_rx_dat);
        checkOutput("gig_byte_count", 16'(got_q.size()), 16'd64);
        for (int k = 0; k < 4; k++) applyStimulus(1'b0, 4'h0, 4'h0, 1'b0, 1'b0);

        // In-band 100M full duplex: 3 samples, break, then 4 samples
        for (int k = 0; k < 3; k++) applyStimulus(1'b0, 4'b1011, 4'h0, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'b1011, 4'h0, 1'b0, 1'b1);
        checkOutput("inband_no_early_link", 16'(link_up), 16'h0);
        checkOutput("inband_no_early_speed", 16'(speed), 16'(DEF_SPD));
        pulses = 0;
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b0, 4'b1011, 4'h0, 1'b0, 1'b0);
            if (status_chg) pulses++;
        end
        checkOutput("inband_chg_pulses", 16'(pulses), 16'd1);
        checkOutput("inband_speed", 16'(speed), 16'h1);
        checkOutput("inband_link", 16'(link_up), 16'h1);
        checkOutput("inband_duplex", 16'(full_duplex), 16'h1);

        // 100M preamble + SFD + one byte: 15 x 5, D, 3, A
        nibs.delete();
        for (int k = 0; k < 15; k++) nibs.push_back(4'h5);
        nibs.push_back(4'hD); nibs.push_back(4'h3); nibs.push_back(4'hA);
        got_q.delete();
        prev_val = 1'b0;
        for (int k = 0; k <= nibs.size(); k++) begin
            if (k < nibs.size()) applyStimulus(1'b0, nibs[k], 4'h0, 1'b1, 1'b1);
            else                 applyStimulus(1'b0, 4'b1011, 4'h0, 1'b0, 1'b0);
            checkOutput("nib_val_back_to_back", 16'(prev_val & gmii_rx_val), 16'h0);
            prev_val = gmii_rx_val;
            if (gmii_rx_val) got_q.push_back(gmii_rx_dat);
        end
        checkOutput("nib_byte_count", 16'(got_q.size()), 16'd9);
        if (got_q.size() == 9) begin
            checkOutput("nib_preamble", 16'(got_q[0]), 16'h55);
            checkOutput("nib_sfd", 16'(got_q[7]), 16'hD5);
            checkOutput("nib_data", 16'(got_q[8]), 16'hA3);
        end

        // Seven-nibble frame ends on a lone nibble
        nibs = '{4'h2, 4'h1, 4'h4, 4'h3, 4'h6, 4'h5, 4'h9};
        foreach (nibs[k]) applyStimulus(1'b0, nibs[k], 4'h0, 1'b1, 1'b1);
        applyStimulus(1'b0, 4'b1011, 4'h0, 1'b0, 1'b0);
        checkOutput("odd_byte", 16'(gmii_rx_dat), 16'h09);
        checkOutput("odd_err", 16'(gmii_rx_err), 16'h1);
        checkOutput("odd_cnt_one", 16'(odd_nib_cnt), 16'h1);
        checkOutput("err_cnt_one", 16'(rx_err_cnt), 16'h1);

        // Status moves to 1000M; the 4th sample lands as a nibble frame ends
        for (int k = 0; k < 3; k++) applyStimulus(1'b0, 4'b1101, 4'h0, 1'b0, 1'b0);
        nibs = '{4'h8, 4'h7, 4'h6, 4'h5};
        foreach (nibs[k]) applyStimulus(1'b0, nibs[k], 4'h0, 1'b1, 1'b1);
        checkOutput("switch_last_byte", 16'(gmii_rx_dat), 16'h56);
        applyStimulus(1'b0, 4'b1101, 4'h0, 1'b0, 1'b0);
        checkOutput("switch_held", 16'(speed), 16'h1);
        applyStimulus(1'b0, 4'b1101, 4'h0, 1'b0, 1'b0);
        checkOutput("switch_applied", 16'(speed), 16'h2);
        checkOutput("switch_pulse", 16'(status_chg), 16'h1);

        // Back to 100M, then reset while holding a lone low nibble
        for (int k = 0; k < 4; k++) applyStimulus(1'b0, 4'b1011, 4'h0, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'hC, 4'h0, 1'b1, 1'b1);
        applyStimulus(1'b1, 4'h0, 4'h0, 1'b0, 1'b0);
        checkOutput("rst_mid_val", 16'(gmii_rx_val), 16'h0);
        checkOutput("rst_mid_speed", 16'(speed), 16'(DEF_SPD));
        checkOutput("rst_mid_odd", 16'(odd_nib_cnt), 16'h0);
        checkOutput("rst_mid_errc", 16'(rx_err_cnt), 16'h0);
        applyStimulus(1'b0, 4'h0, 4'h0, 1'b0, 1'b1);
        checkOutput("rst_no_partial", 16'(gmii_rx_val), 16'h0);

        // Error counter saturation in gigabit mode
        for (int k = 0; k < 20; k++) applyStimulus(1'b0, 4'h3, 4'h4, 1'b1, 1'b0);
        checkOutput("errc_saturated", 16'(rx_err_cnt), 16'(CNT_SAT));

        // Randomized traffic mixing status runs, frames, carrier extend, resets
        for (int seg = 0; seg < 400; seg++) begin
            kind = $urandom_range(0, 9);
            if (kind < 4) begin
                s   = stat_tab[$urandom_range(0, 5)];
                len = $urandom_range(1, 6);
                for (int k = 0; k < len; k++) applyStimulus(1'b0, s, 4'($urandom), 1'b0, 1'b0);
            end else if (kind < 8) begin
                len = $urandom_range(1, 12);
                for (int k = 0; k < len; k++)
                    applyStimulus(1'b0, 4'($urandom), 4'($urandom), 1'b1, ($urandom_range(0, 7) != 0));
            end else if (kind == 8) begin
                len = $urandom_range(1, 3);
                for (int k = 0; k < len; k++) applyStimulus(1'b0, 4'($urandom), 4'($urandom), 1'b0, 1'b1);
            end else begin
                applyStimulus(($urandom_range(0, 3) == 0), 4'($urandom), 4'($urandom), 1'b0, 1'b0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/rgmii_rx_mode_adapter.md
Name: rgmii_rx_mode_adapter

Overview:
Second-generation RGMII receive datapath stage. It sits between the RX DDR input cells and the MAC.
- Rebuilds GMII bytes for 1000 Mb/s (byte per clock) and 10/100 Mb/s (nibble per clock, two-nibble assembly).
- Decodes and filters RGMII in-band link status to select the mode automatically.
- Counts framing anomalies.
- All logic runs in the recovered RX clock domain.

Parameters:
- SPEED_AUTO, 1: 1 = mode follows filtered in-band status; 0 = mode follows speed_force only.
- DEFAULT_SPEED, 2'b10: speed code after reset (00 = 10M, 01 = 100M, 10 = 1000M).
- STATUS_FILTER, 4: consecutive identical in-band samples required before status is accepted (min 1, max 255).
- CNT_W, 16: width of the anomaly counters.

Ports:
- clk  in  1  recovered RX clock; all logic rising-edge
- rst  in  1  synchronous active-high reset
- ddr_dat_l  in  4  DDR data, rising-edge half
- ddr_dat_h  in  4  DDR data, falling-edge half
- ddr_ctl_l  in  1  RX_CTL, rising-edge half (RX_DV)
- ddr_ctl_h  in  1  RX_CTL, falling-edge half (RX_DV xor RX_ER)
- speed_force  in  2  speed code used when SPEED_AUTO = 0
- gmii_rx_dat  out  8  byte
- gmii_rx_val  out  1  byte valid
- gmii_rx_err  out  1  byte error
- link_up  out  1  filtered link status
- speed  out  2  active speed code
- full_duplex  out  1  filtered duplex
- status_chg  out  1  one-cycle pulse when link_up, speed or full_duplex changes
- odd_nib_cnt  out  CNT_W  saturating count of frames ending on a lone nibble
- rx_err_cnt  out  CNT_W  saturating count of bytes emitted with gmii_rx_err = 1

Behaviour:
Reset values:
- rst = 1 clears all outputs and counters to 0, except speed, which loads DEFAULT_SPEED.
- The status filter counter clears to 0.
- The FSM goes to IDLE.
- A reset mid-frame discards the partial byte; no val is emitted.

Decoding per cycle:
- dv = ddr_ctl_l
- er = ddr_ctl_l ^ ddr_ctl_h

Gigabit mode (speed = 10):
- gmii_rx_dat = {ddr_dat_h, ddr_dat_l}, gmii_rx_val = dv, gmii_rx_err = er.
- All three are registered; latency is 1 cycle.

Nibble mode (speed = 00/01), FSM IDLE / LOW / HIGH:
- IDLE: on dv = 1, capture ddr_dat_l as the low nibble and OR er into the pending error; go to HIGH.
- HIGH with dv = 1: emit {ddr_dat_l, low} with val = 1 and err = pending | er, latency 1 cycle; go to LOW.
- HIGH with dv = 0 (odd nibble count): emit {4'h0, low} with val = 1 and err = 1; increment odd_nib_cnt; go to IDLE.
- LOW with dv = 1: capture the low nibble; go to HIGH.
- LOW with dv = 0: go to IDLE, no output.
- gmii_rx_val is never high on two consecutive cycles in nibble mode.
- The high half of the DDR input is ignored in nibble mode, except for error derivation.

In-band status:
- A sample is taken only when ddr_ctl_l = 0 and ddr_ctl_h = 0.
- Fields: link = dat_l[0], speed = dat_l[2:1], duplex = dat_l[3].
- Samples with code 11 are treated as invalid: the filter counter resets.
- A sample equal to the previous sample increments the filter counter, saturating at STATUS_FILTER; otherwise the counter reloads to 1.
- When the counter reaches STATUS_FILTER and the sample differs from the current outputs, update link_up and full_duplex and pulse status_chg.
- ctl_l = 0, ctl_h = 1 (carrier extend / false carrier) holds the counter.

Mode switching:
- The new speed (filtered status if SPEED_AUTO = 1, speed_force if 0) is applied only when the FSM is in IDLE and dv = 0.
- Otherwise it is held pending and applied on the first such cycle.
- If speed changes by itself, status_chg pulses once, on the cycle the speed output changes.
- A link_up = 0 status does not change speed.

Counters:
- rx_err_cnt increments on every emitted byte with err = 1, including odd-nibble terminations.
- Both counters saturate at all-ones; they do not wrap.

Decomposition:
- Shared package rgmii_pkg: typedef enum speed_t {SPD_10 = 2'b00, SPD_100 = 2'b01, SPD_1000 = 2'b10}, struct rgmii_status_t {link, speed, duplex}, and the nibble FSM state enum.
- One sub-module, rgmii_inband_status_filter: sample qualification, filter counter, and status_chg generation.

Test Plan:
- Gig mode, 64-byte frame with dat_l = byte[3:0] and dat_h = byte[7:4] -> identical bytes on gmii_rx_dat, 1 cycle later, val = 1 for 64 cycles, err = 0.
- Force 100M; nibbles 5,5,…,5,D then 3,A -> bytes 0x55…0xD5, then 0xA3, val on every second cycle.
- Nibble mode, 7-nibble frame -> 3 good bytes, then {0, nib7} with err = 1; odd_nib_cnt = 1, rx_err_cnt = 1.
- In-band dat_l = 4'b1011 for 3 cycles, then break with ctl ≠ 00 (STATUS_FILTER = 4) -> no change; the same value for 4 cycles -> link_up = 1, speed = 01, full_duplex = 1, one status_chg pulse.
- Status switches to 1000M while a nibble frame is active -> speed stays 01 until the cycle after dv falls and the FSM is IDLE, then 10; frame bytes are unaffected.
- Assert rst while the FSM is in HIGH -> next cycle: val = 0, speed = DEFAULT_SPEED, counters = 0, no partial byte emitted.
